sound_path: RTL and testbench
=============================

# sound_path

Digital audio voice generator for the synthesizer datapath. Runs on the 12 MHz system clock; a free-running period counter tracks position within one waveform period of `divisor` clocks. On each `sample_now` strobe it derives an 8-bit phase with a sequential divider and shapes it into the selected waveform. It emits one 8-bit sample plus a `done` strobe for the downstream PWM/DAC stage, which issues `sample_now` once every 256 clocks.

## Interface
- No parameters. Widths are fixed: divisor 19 bits, sample 8 bits.
- `clk` in 1: system clock, 12 MHz.
- `n_rst` in 1: asynchronous, active-low reset.
- `sample_now` in 1: sample request strobe, nominally 1 cycle high every 256.
- `mode` in 2: waveform select. 0 square, 1 sawtooth, 2 triangle, 3 noise.
- `divisor` in 19: clocks per waveform period (2658 ≈ 4.5 kHz).
- `sample` out 8: current sample. Holds its value between updates.
- `done` out 1: one-cycle pulse when `sample` updates.

## Operation
- **Period counter `cnt`** (19 bits):
  - Each clock: if `divisor < 2` or `cnt >= divisor-1`, then `cnt <= 0`.
  - Otherwise `cnt <= cnt+1`.
  - A shrinking `divisor` therefore wraps the counter on the next clock.
- **Capture:**
  - Applies when `sample_now`=1 at a rising edge while IDLE.
  - Latches the pre-increment `cnt`, `divisor` and `mode`, then enters BUSY.
  - `sample_now` while BUSY is ignored.
- **Divider:**
  - Restoring division, one quotient bit per clock, MSB first, 8 iterations.
  - Computes `phase = floor(cnt*256 / divisor)`.
  - The result is always < 256 because `cnt < divisor`.
  - If the captured `divisor < 2`, `phase = 0`.
- **Shaping**, with p = phase:
  - Square: p < 128 → 8'hFF, else 8'h00.
  - Sawtooth: p.
  - Triangle: p < 128 → {p[6:0],1'b0}; else 8'hFF − {p[6:0],1'b0}.
  - Noise: 16-bit Fibonacci LFSR, step `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
    - Steps once per completed sample, in every mode.
    - Output is the low byte of the new LFSR value.
- **FSM:** IDLE → BUSY (capture) → DONE (after 8 divide cycles) → IDLE.
  - DONE registers `sample` and asserts `done`.

## Timing
- **Reset values:** `sample`=8'h00, `done`=0, `cnt`=0, `lfsr`=16'hACE1, FSM=IDLE.
- **Latency:**
  - Capture at edge k; quotient bits resolve at edges k+1..k+8.
  - `sample` and `done` update at edge k+9.
  - `done` is high for exactly one cycle.
- **Throughput:** at most one sample per 10 clocks. A 256-clock strobe rate never collides with BUSY.
- **Input changes while BUSY:** changes to `mode`/`divisor` do not affect the in-flight sample. They take effect at the next capture.
- **Reset mid-operation:** aborts the division, returns to reset values, and no `done` is emitted.
- **Simultaneous events:** a `sample_now` in the same cycle that DONE asserts `done` is ignored, because the FSM is not IDLE.

## Structure
- **Shared package `sound_pkg`:**
  - `mode_t` enum: SQUARE=0, SAW=1, TRI=2, NOISE=3.
  - FSM state enum.
  - `LFSR_SEED` = 16'hACE1.
  - Width constants DIV_W=19, SAMPLE_W=8.
- **Sub-module `phase_divider`:**
  - 8-iteration sequential restoring divider.
  - Interface: start/busy/valid, 27-bit dividend, 19-bit divisor, 8-bit quotient.
- The top level holds the counter, FSM, LFSR and shaping mux.

## Test plan
- **Square/saw/triangle at half period.** Reset, `divisor`=2658, strobe when captured `cnt`=1329.
  - mode0 → `sample`=8'h00.
  - mode1 → 8'h80.
  - mode2 → 8'hFF.
  - `done` pulses at exactly capture+9.
- **Period start.** `divisor`=2658, captured `cnt`=0.
  - mode0 → 8'hFF.
  - mode1 → 8'h00.
  - mode2 → 8'h00.
- **Triangle falling edge.** `divisor`=256, `cnt`=100 → saw 8'h64, tri 8'hC8; `cnt`=200 → tri 8'h6F.
- **Noise.** First sample after reset in mode3 → 8'hC3 (LFSR 16'h59C3). Successive samples follow the LFSR sequence.
- **Degenerate divisor.** `divisor`=0 or 1 → phase 0; mode1 → 8'h00.
  - Shrink `divisor` below `cnt` → `cnt` is 0 on the next clock.
- **Robustness.**
  - Second `sample_now` while BUSY → exactly one `done`.
  - Assert `n_rst` during BUSY → `sample`=0, no `done`.
  - Change `mode` while BUSY → the in-flight sample uses the old mode.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types, constants and helpers for the sound_path voice generator.
package sound_pkg;

  localparam int DIV_W      = 19;
  localparam int SAMPLE_W   = 8;
  localparam int PHASE_W    = 8;
  localparam int DIVIDEND_W = DIV_W + PHASE_W;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    SQUARE = 2'd0,
    SAW    = 2'd1,
    TRI    = 2'd2,
    NOISE  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One step of the 16-bit Fibonacci LFSR (taps 16,14,13,11).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Map an 8-bit phase to the selected waveform; noise comes from the caller.
  function automatic logic [SAMPLE_W-1:0] shape(input mode_t m,
                                                input logic [PHASE_W-1:0] p,
                                                input logic [SAMPLE_W-1:0] noise);
    logic [SAMPLE_W-1:0] r;
    case (m)
      SQUARE:  r = p[7] ? 8'h00 : 8'hFF;
      SAW:     r = p;
      TRI:     r = p[7] ? (8'hFF - {p[6:0], 1'b0}) : {p[6:0], 1'b0};
      default: r = noise;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/phase_divider.sv
// Sequential restoring divider producing an 8-bit quotient, one bit per clock.
// The dividend's upper DIV_W bits seed the remainder (they must be below the
// divisor), the low 8 bits are shifted in MSB first. Divisors below 2 yield 0.
module phase_divider
  import sound_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIV_W-1:0]      divisor,
  output logic                  busy,
  output logic                  valid,
  output logic [PHASE_W-1:0]    quotient
);

  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             degen_q, degen_d;
  logic [2:0]       iter_q, iter_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       low_q, low_d;
  logic [7:0]       quo_q, quo_d;

  // Trial subtraction: the bit shifted out of the remainder guarantees ge.
  logic             trial_hi;
  logic [DIV_W-1:0] trial_lo;
  logic             ge;

  // Next-state logic: load on start, otherwise iterate while busy.
  always_comb begin
    busy_d   = busy_q;
    valid_d  = 1'b0;
    degen_d  = degen_q;
    iter_d   = iter_q;
    rem_d    = rem_q;
    div_d    = div_q;
    low_d    = low_q;
    quo_d    = quo_q;
    trial_hi = rem_q[DIV_W-1];
    trial_lo = {rem_q[DIV_W-2:0], low_q[7]};
    ge       = trial_hi | (trial_lo >= div_q);
    if (busy_q) begin
      rem_d  = ge ? (trial_lo - div_q) : trial_lo;
      quo_d  = {quo_q[6:0], ge};
      low_d  = {low_q[6:0], 1'b0};
      iter_d = iter_q + 3'd1;
      if (iter_q == 3'd7) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end else if (start) begin
      rem_d   = dividend[DIVIDEND_W-1:PHASE_W];
      low_d   = dividend[PHASE_W-1:0];
      quo_d   = '0;
      iter_d  = '0;
      div_d   = divisor;
      degen_d = (divisor < 19'd2);
      busy_d  = 1'b1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      degen_q <= 1'b0;
      iter_q  <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      low_q   <= '0;
      quo_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      degen_q <= degen_d;
      iter_q  <= iter_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      low_q   <= low_d;
      quo_q   <= quo_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign quotient = degen_q ? '0 : quo_q;

endmodule

// File: rtl/sound_path.sv
// Voice generator: period counter, capture FSM, LFSR and waveform shaping.
// A capture at edge k yields sample/done at edge k+9; done lasts one cycle.
module sound_path
  import sound_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  input  logic                sample_now,
  input  logic [1:0]          mode,
  input  logic [DIV_W-1:0]    divisor,
  output logic [SAMPLE_W-1:0] sample,
  output logic                done
);

  logic [DIV_W-1:0]    cnt_q, cnt_d;
  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                done_q, done_d;

  logic                capture;
  logic                div_busy;
  logic                div_valid;
  logic [PHASE_W-1:0]  phase;

  // Free-running period counter; wraps immediately if divisor shrinks below it.
  always_comb begin
    cnt_d = cnt_q + 19'd1;
    if ((divisor < 19'd2) || (cnt_q >= divisor - 19'd1)) begin
      cnt_d = '0;
    end
  end

  assign capture = (state_q == ST_IDLE) && sample_now && !div_busy;

  phase_divider u_div (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (capture),
    .dividend ({cnt_q, 8'h00}),
    .divisor  (divisor),
    .busy     (div_busy),
    .valid    (div_valid),
    .quotient (phase)
  );

  // FSM next state, LFSR advance and sample shaping on divide completion.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    lfsr_d   = lfsr_q;
    sample_d = sample_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (capture) begin
          mode_d  = mode_t'(mode);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (div_valid) begin
          lfsr_d   = lfsr_step(lfsr_q);
          sample_d = shape(mode_q, phase, lfsr_d[7:0]);
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Top-level state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      mode_q   <= SQUARE;
      lfsr_q   <= LFSR_SEED;
      sample_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      mode_q   <= mode_d;
      lfsr_q   <= lfsr_d;
      sample_q <= sample_d;
      done_q   <= done_d;
    end
  end

  assign sample = sample_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sound_path.sv
// Self-checking bench for sound_path: directed table, corner sequences and
// randomized captures checked against an arithmetic reference model.
module tb_sound_path;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        sample_now = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [18:0] divisor = 19'd2658;
  logic [7:0]  sample;
  logic        done;

  int total = 0;
  int bad = 0;

  // Reference model state: counter position and noise generator.
  int          m_cnt = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  sound_path dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .sample_now (sample_now),
    .mode       (mode),
    .divisor    (divisor),
    .sample     (sample),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Counter model: position within the period, wrapping at divisor.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) m_cnt <= 0;
    else if (int'(divisor) < 2 || m_cnt >= int'(divisor) - 1) m_cnt <= 0;
    else m_cnt <= m_cnt + 1;
  end

  typedef struct {
    logic [1:0] md;
    int         dv;
    int         ct;
    int         ex;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [15:0] next_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return (s << 1) | {15'd0, fb};
  endfunction

  function automatic int ref_sample(input int md, input int ct, input int dv, input int noise);
    int p;
    p = (dv < 2) ? 0 : ((ct * 256) / dv) % 256;
    case (md)
      0: return (p < 128) ? 255 : 0;
      1: return p;
      2: return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      default: return noise;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Advance until the counter the next edge will capture equals target.
  task automatic wait_cnt(input int target, input int budget);
    bit found;
    found = 0;
    for (int n = 0; n < budget; n++) begin
      if (m_cnt == target) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!found) check("wait_cnt_timeout", 0, 1);
  endtask

  // Strobe once, then watch 20 edges for done timing, sample value and hold.
  task automatic run_sample(input string name, input int exp, input int extra_at,
                            input int chg_at, input logic [1:0] chg_mode);
    int pulses;
    int first;
    int got;
    int held;
    pulses = 0; first = -1; got = -1; held = -1;
    sample_now = 1'b1;
    @(posedge clk); #1;
    sample_now = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == 9) got = int'(sample);
      if (i == 20) held = int'(sample);
      if (i == extra_at) sample_now = 1'b1;
      if (i == extra_at + 1) sample_now = 1'b0;
      if (i == chg_at) mode = chg_mode;
    end
    check({name, "_sample"}, got, exp);
    check({name, "_done_at"}, first, 9);
    check({name, "_done_cnt"}, pulses, 1);
    check({name, "_hold"}, held, exp);
    m_lfsr = next_lfsr(m_lfsr);
    $display("txn %s div=%0d sample=%02h want=%02h done_at=%0d pulses=%0d",
             name, divisor, got[7:0], exp[7:0], first, pulses);
  endtask

  initial begin
    logic [15:0] nx;
    int dv, ct, md, ex, pulses;

    vecs[0]  = '{2'd0, 2658, 1329, 8'h00};
    vecs[1]  = '{2'd1, 2658, 1329, 8'h80};
    vecs[2]  = '{2'd2, 2658, 1329, 8'hFF};
    vecs[3]  = '{2'd0, 2658, 0,    8'hFF};
    vecs[4]  = '{2'd1, 2658, 0,    8'h00};
    vecs[5]  = '{2'd2, 2658, 0,    8'h00};
    vecs[6]  = '{2'd1, 256,  100,  8'h64};
    vecs[7]  = '{2'd2, 256,  100,  8'hC8};
    vecs[8]  = '{2'd2, 256,  200,  8'h6F};
    vecs[9]  = '{2'd1, 0,    0,    8'h00};
    vecs[10] = '{2'd1, 1,    0,    8'h00};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_sample", int'(sample), 0);
    check("reset_done", int'(done), 0);
    n_rst = 1'b1;

    // First noise sample after reset.
    mode = 2'd3; divisor = 19'd2658;
    wait_cnt(50, 6000);
    run_sample("noise_first", 8'hC3, -5, -5, 2'd0);

    // Directed table.
    for (int v = 0; v < 11; v++) begin
      mode = vecs[v].md;
      divisor = 19'(vecs[v].dv);
      wait_cnt(vecs[v].ct, 6000);
      run_sample($sformatf("vec%0d", v), vecs[v].ex, -5, -5, 2'd0);
    end

    // Shrinking divisor wraps the counter on the next clock.
    mode = 2'd1; divisor = 19'd2658;
    wait_cnt(1000, 6000);
    divisor = 19'd300;
    @(posedge clk); #1;
    run_sample("shrink", 8'h00, -5, -5, 2'd0);

    // Second strobe while busy, and strobe during the done cycle.
    mode = 2'd1; divisor = 19'd2658;
    wait_cnt(1329, 6000);
    run_sample("strobe_busy", 8'h80, 3, -5, 2'd0);
    wait_cnt(1329, 6000);
    run_sample("strobe_done", 8'h80, 9, -5, 2'd0);

    // Mode change in flight: square at period start, switched to saw.
    mode = 2'd0;
    wait_cnt(0, 6000);
    run_sample("mode_chg", 8'hFF, -5, 2, 2'd1);

    // Reset while busy aborts the sample without a done pulse.
    mode = 2'd1;
    wait_cnt(1329, 6000);
    sample_now = 1'b1;
    @(posedge clk); #1;
    sample_now = 1'b0;
    repeat (4) @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    check("abort_sample", int'(sample), 0);
    check("abort_done", int'(done), 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    m_lfsr = 16'hACE1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 0);
    $display("txn abort sample=%02h pulses=%0d", sample, pulses);

    // Noise restarts from the seed after the aborted sample.
    mode = 2'd3;
    wait_cnt(7, 6000);
    run_sample("noise_after_rst", 8'hC3, -5, -5, 2'd0);

    // Randomized captures against the reference model.
    for (int r = 0; r < 30; r++) begin
      md = int'($urandom_range(0, 3));
      dv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 600));
      ct = (dv < 2) ? 0 : int'($urandom_range(0, dv - 1));
      mode = 2'(md);
      divisor = 19'(dv);
      wait_cnt(ct, 2 * dv + 20);
      nx = next_lfsr(m_lfsr);
      ex = ref_sample(md, ct, dv, int'(nx[7:0]));
      run_sample($sformatf("rnd%0d_m%0d_c%0d", r, md, ct), ex, -5, -5, 2'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
